axis_read_seq: RTL and testbench



---
 rtl/axis_read_seq.sv | 168 ++++++++++++++++
 tb/tb_axis_read_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_read_seq.sv
// Descriptor sequencer: replays (addr, len) as SEL/ADDR/LEN config words to the
// stream read engine, then counts accepted output beats until the transfer completes.
module axis_read_seq #(
    parameter int unsigned CONFIG_ID     = 1,
    parameter int unsigned CONFIG_ADDR   = 23,
    parameter int unsigned CONFIG_DATA   = 24,
    parameter int unsigned CONFIG_AWIDTH = 5,
    parameter int unsigned CONFIG_DWIDTH = 32,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CONFIG_DWIDTH-1:0] desc_addr,
    input  logic [CONFIG_DWIDTH-1:0] desc_len,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    output logic [CONFIG_AWIDTH-1:0] cfg_addr,
    output logic [CONFIG_DWIDTH-1:0] cfg_data,
    output logic                     cfg_valid,
    input  logic                     mon_valid,
    input  logic                     mon_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_GAP,
        S_ADDR,
        S_LEN,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CONFIG_DWIDTH-1:0] addr_q, addr_d;
    logic [CONFIG_DWIDTH-1:0] len_q, len_d;
    logic [CONFIG_DWIDTH-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     err_q, err_d;
    logic                     ready_q, ready_d;
    logic                     cfg_valid_q, cfg_valid_d;
    logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     beat;
    logic                     counting;

    assign beat     = mon_valid & mon_ready;
    assign counting = (state_q == S_SEL) || (state_q == S_GAP) || (state_q == S_ADDR) ||
                      (state_q == S_LEN) || (state_q == S_STREAM);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;

        // Saturate at len so early beats during the cfg words cannot overshoot.
        if (counting && beat && (cnt_q != len_q)) begin
            cnt_d = cnt_q + CONFIG_DWIDTH'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (desc_valid && ready_q) begin
                    addr_d  = desc_addr;
                    len_d   = desc_len;
                    cnt_d   = '0;
                    wd_d    = '0;
                    err_d   = 1'b0;
                    state_d = (desc_len != '0) ? S_SEL : S_DONE;
                end
            end
            S_SEL:  state_d = S_GAP;
            S_GAP:  state_d = S_ADDR;
            S_ADDR: state_d = S_LEN;
            S_LEN:  state_d = S_STREAM;
            S_STREAM: begin
                if (cnt_d == len_q) begin
                    state_d = S_DONE;
                end else if (beat) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + TIMEOUT_WIDTH'(1);
                    if (wd_d == '1) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state's cycle.
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        cfg_valid_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        unique case (state_d)
            S_SEL: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
                cfg_data_d  = CONFIG_DWIDTH'(CONFIG_ID);
            end
            S_ADDR: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = addr_q;
            end
            S_LEN: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = len_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign desc_ready = ready_q;
    assign cfg_valid  = cfg_valid_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_axis_read_seq.sv
// Directed bench for axis_read_seq: reset, normal transfer, zero length,
// throttled beats with back-to-back descriptor, watchdog trip and mid-sequence reset.
module tb_axis_read_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] desc_addr;
    logic [31:0] desc_len;
    logic        desc_valid;
    logic        desc_ready;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        mon_valid;
    logic        mon_ready;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    axis_read_seq #(
        .TIMEOUT_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .desc_addr (desc_addr),
        .desc_len  (desc_len),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .mon_valid (mon_valid),
        .mon_ready (mon_ready),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, {31'b0, cfg_valid}, 32'd1);
        chk({tag, "_addr"}, {27'b0, cfg_addr}, {27'b0, a});
        chk({tag, "_data"}, cfg_data, d);
    endtask

    initial begin
        rst_n      = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        desc_valid = 1'b0;
        mon_valid  = 1'b0;
        mon_ready  = 1'b0;

        // Reset for three cycles
        repeat (3) tick();
        chk("rst_ready", {31'b0, desc_ready}, 32'd0);
        chk("rst_cfg_valid", {31'b0, cfg_valid}, 32'd0);
        chk("rst_cfg_addr", {27'b0, cfg_addr}, 32'd0);
        chk("rst_cfg_data", cfg_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {31'b0, desc_ready}, 32'd1);

        // Normal transfer: len=8, beats in cycles 6..13
        desc_addr  = 32'h1000_0000;
        desc_len   = 32'd8;
        desc_valid = 1'b1;
        mon_ready  = 1'b1;
        tick();                                   // cycle 1
        desc_valid = 1'b0;
        chk_cfg("n_sel", 5'd23, 32'd1);
        chk("n_busy1", {31'b0, busy}, 32'd1);
        chk("n_ready1", {31'b0, desc_ready}, 32'd0);
        tick();                                   // cycle 2
        chk("n_gap", {31'b0, cfg_valid}, 32'd0);
        tick();                                   // cycle 3
        chk_cfg("n_addr", 5'd24, 32'h1000_0000);
        tick();                                   // cycle 4
        chk_cfg("n_len", 5'd24, 32'd8);
        tick();                                   // cycle 5
        chk("n_stream_cv", {31'b0, cfg_valid}, 32'd0);
        tick();                                   // cycle 6
        for (int i = 0; i < 8; i++) begin
            mon_valid = 1'b1;
            chk("n_nodone", {31'b0, done}, 32'd0);
            chk("n_ready_lo", {31'b0, desc_ready}, 32'd0);
            tick();
        end                                       // cycle 14
        mon_valid = 1'b0;
        chk("n_done", {31'b0, done}, 32'd1);
        chk("n_done_busy", {31'b0, busy}, 32'd1);
        chk("n_done_ready", {31'b0, desc_ready}, 32'd0);
        tick();                                   // cycle 15
        chk("n_done_off", {31'b0, done}, 32'd0);
        chk("n_busy_off", {31'b0, busy}, 32'd0);
        chk("n_ready_back", {31'b0, desc_ready}, 32'd1);

        // Zero length
        desc_len   = 32'd0;
        desc_valid = 1'b1;
        tick();                                   // cycle 1
        desc_valid = 1'b0;
        chk("z_done", {31'b0, done}, 32'd1);
        chk("z_cv1", {31'b0, cfg_valid}, 32'd0);
        chk("z_busy", {31'b0, busy}, 32'd1);
        chk("z_ready1", {31'b0, desc_ready}, 32'd0);
        tick();                                   // cycle 2
        chk("z_ready2", {31'b0, desc_ready}, 32'd1);
        chk("z_done2", {31'b0, done}, 32'd0);
        chk("z_cv2", {31'b0, cfg_valid}, 32'd0);

        // len=4, mon_ready high on odd cycles, desc_valid held: beats at 1,3,5,7
        desc_addr  = 32'h0000_2000;
        desc_len   = 32'd4;
        desc_valid = 1'b1;
        mon_valid  = 1'b1;
        mon_ready  = 1'b0;
        tick();                                   // cycle 1
        for (int c = 1; c <= 8; c++) begin
            mon_ready = (c % 2 == 1);
            chk("t_done", {31'b0, done}, (c == 8) ? 32'd1 : 32'd0);
            chk("t_ready_lo", {31'b0, desc_ready}, 32'd0);
            tick();
        end                                       // cycle 9
        mon_ready = 1'b0;
        chk("t_ready_back", {31'b0, desc_ready}, 32'd1);
        chk("t_busy_off", {31'b0, busy}, 32'd0);
        tick();                                   // second descriptor, cycle 1
        desc_valid = 1'b0;
        chk_cfg("t2_sel", 5'd23, 32'd1);
        chk("t2_busy", {31'b0, busy}, 32'd1);

        // Second descriptor doubles as the watchdog case: 2 beats then silence
        for (int c = 1; c <= 21; c++) begin
            mon_ready = (c == 5 || c == 6);
            chk("w_nodone", {31'b0, done}, 32'd0);
            chk("w_noerr", {31'b0, error}, 32'd0);
            chk("w_busy", {31'b0, busy}, 32'd1);
            tick();
        end                                       // cycle 22
        mon_ready = 1'b0;
        chk("w_err", {31'b0, error}, 32'd1);
        chk("w_busy_off", {31'b0, busy}, 32'd0);
        chk("w_done", {31'b0, done}, 32'd0);
        chk("w_ready", {31'b0, desc_ready}, 32'd1);
        tick();
        chk("w_sticky", {31'b0, error}, 32'd1);

        // Next acceptance clears error; then reset during the ADDR word
        mon_valid  = 1'b0;
        desc_addr  = 32'h0000_5555;
        desc_len   = 32'd1;
        desc_valid = 1'b1;
        tick();                                   // cycle 1
        desc_valid = 1'b0;
        chk("c_err_clr", {31'b0, error}, 32'd0);
        chk("c_busy", {31'b0, busy}, 32'd1);
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        chk_cfg("r_addr", 5'd24, 32'h0000_5555);
        rst_n = 1'b0;
        tick();
        chk("r_cv", {31'b0, cfg_valid}, 32'd0);
        chk("r_busy", {31'b0, busy}, 32'd0);
        chk("r_ready", {31'b0, desc_ready}, 32'd0);
        chk("r_cfg_addr", {27'b0, cfg_addr}, 32'd0);
        chk("r_cfg_data", cfg_data, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("r_ready_back", {31'b0, desc_ready}, 32'd1);

        // Fresh descriptor replays the full sequence
        desc_addr  = 32'hABCD_0123;
        desc_len   = 32'd2;
        desc_valid = 1'b1;
        tick();                                   // cycle 1
        desc_valid = 1'b0;
        chk_cfg("f_sel", 5'd23, 32'd1);
        tick();                                   // cycle 2
        chk("f_gap", {31'b0, cfg_valid}, 32'd0);
        tick();                                   // cycle 3
        chk_cfg("f_addr", 5'd24, 32'hABCD_0123);
        tick();                                   // cycle 4
        chk_cfg("f_len", 5'd24, 32'd2);
        tick();                                   // cycle 5
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        tick();                                   // cycle 6
        chk("f_nodone", {31'b0, done}, 32'd0);
        tick();                                   // cycle 7
        mon_valid = 1'b0;
        chk("f_done", {31'b0, done}, 32'd1);
        tick();                                   // cycle 8
        chk("f_busy_off", {31'b0, busy}, 32'd0);
        chk("f_ready", {31'b0, desc_ready}, 32'd1);
        chk("f_err", {31'b0, error}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
